instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Accepts RV32 instruction field requests, encodes each into a 32-bit word
// and writes it to consecutive instruction-memory addresses within a session.
//
// state | meaning
// IDLE  | no session open, waiting for start
// RUN   | accepting requests (in_ready high)
// WRITE | one-cycle write of the encoded word to imem
// FULL  | DEPTH words written, requests stalled until finish
module instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              busy,
  output logic              err_illegal
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, FULL} state_t;

  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [31:0]       enc;
  logic              legal;

  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    case (fmt)
      3'd0: enc = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      3'd1: enc = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      3'd2: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      3'd3: enc = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      3'd4: begin
        enc   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
        legal = ~imm[0];
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        // a handshake wins over a simultaneous finish
        if (in_valid) begin
          if (legal) begin
            wdata_d = enc;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      WRITE: begin
        count_d = count_q + CNT_ONE;
        // pointer parks on the last address once full so it never wraps
        if (count_d == CNT_DEPTH) begin
          state_d = FULL;
        end else begin
          ptr_d   = ptr_q + PTR_ONE;
          state_d = RUN;
        end
      end
      FULL: begin
        if (finish) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign in_ready    = (state_q == RUN);
  assign imem_we     = (state_q == WRITE);
  assign full        = (state_q == FULL);
  assign busy        = (state_q != IDLE);
  assign imem_addr   = ptr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with a small, non-power-of-two depth.
module tb_instr_encoder;

  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst, start, finish, in_valid, in_ready;
  logic [2:0]        fmt;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [12:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, done, busy, err_illegal;

  int n_vec = 0;
  int n_bad = 0;
  bit ok;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .done(done), .busy(busy), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_finish();
    @(negedge clk);
    finish = 1'b1;
    @(posedge clk);
    #1 finish = 1'b0;
  endtask

  // returns 1 ns after the handshake edge, i.e. inside the WRITE cycle for legal requests
  task automatic send(input logic [2:0] f, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                      input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] im, output bit hs);
    @(negedge clk);
    fmt = f; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        hs = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (hs) @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    fmt = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 13'd0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_illegal, 0);
    rst = 1'b0;

    // single I-type write with one cycle of latency
    do_start();
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, ok);
    check("i_hs", ok, 1);
    check("i_we", imem_we, 1);
    check("i_addr", imem_addr, 0);
    check("i_wdata", imem_wdata, 32'h00500093);
    @(posedge clk); #1;
    check("i_count", count, 1);
    check("i_we_off", imem_we, 0);
    check("i_addr_next", imem_addr, 1);
    check("i_wdata_hold", imem_wdata, 32'h00500093);
    do_finish();
    check("i_done", done, 1);
    check("i_idle", busy, 0);
    @(posedge clk); #1;
    check("i_done_pulse", done, 0);

    // R, S, L, B sequence
    wa.delete(); wd.delete();
    do_start();
    check("seq_count_clr", count, 0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, ok); check("r_hs", ok, 1);
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'd8, ok); check("s_hs", ok, 1);
    send(3'd3, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 13'd4, ok); check("l_hs", ok, 1);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd8, ok); check("b_hs", ok, 1);
    @(posedge clk); #1;
    check("seq_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      check("seq_a0", wa[0], 0); check("seq_d0", wd[0], 32'h002081B3);
      check("seq_a1", wa[1], 1); check("seq_d1", wd[1], 32'h0020A423);
      check("seq_a2", wa[2], 2); check("seq_d2", wd[2], 32'h0040A283);
      check("seq_a3", wa[3], 3); check("seq_d3", wd[3], 32'h00208463);
    end
    check("seq_count", count, 4);
    do_finish();
    check("seq_done", done, 1);

    // illegal requests, then a legal one; imm[12] must not leak into I
    wa.delete(); wd.delete();
    do_start();
    send(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, ok);
    check("ill5_hs", ok, 1);
    check("ill5_we", imem_we, 0);
    check("ill5_err", err_illegal, 1);
    check("ill5_ready", in_ready, 1);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd7, ok);
    check("illb_we", imem_we, 0);
    check("illb_count", count, 0);
    send(3'd1, 5'd2, 5'd3, 5'd0, 3'd1, 7'd0, 13'h1009, ok);
    check("ill_next_we", imem_we, 1);
    check("ill_next_addr", imem_addr, 0);
    check("ill_next_wdata", imem_wdata, 32'h00919113);
    check("ill_err_sticky", err_illegal, 1);
    @(posedge clk); #1;
    check("ill_nwr", wa.size(), 1);
    do_finish();
    do_start();
    check("err_cleared", err_illegal, 0);

    // fill to DEPTH, stall, then finish
    wa.delete(); wd.delete();
    for (int i = 0; i < DEPTH; i++) begin
      send(3'd1, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 13'(i), ok);
      check("fill_hs", ok, 1);
    end
    check("fill_last_addr", imem_addr, DEPTH - 1);
    check("fill_last_wdata", imem_wdata, 32'h00500293);
    @(negedge clk);
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("full_flag", full, 1);
    check("full_ready", in_ready, 0);
    check("full_count", count, DEPTH);
    check("full_addr", imem_addr, DEPTH - 1);
    check("full_nwr", wa.size(), DEPTH);
    if (wa.size() == DEPTH)
      for (int i = 0; i < DEPTH; i++) check("fill_addr", wa[i], i);
    in_valid = 1'b0;
    do_finish();
    check("full_done", done, 1);
    check("full_idle", busy, 0);
    check("full_clr", full, 0);

    // handshake beats finish; finish during WRITE ignored
    do_start();
    @(negedge clk);
    fmt = 3'd1; rd = 5'd1; rs1 = 5'd0; funct3 = 3'd0; imm = 13'd5;
    in_valid = 1'b1; finish = 1'b1;
    check("pri_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("pri_we", imem_we, 1);
    check("pri_done", done, 0);
    check("pri_busy", busy, 1);
    @(posedge clk); #1;
    check("wr_fin_done", done, 0);
    check("wr_fin_count", count, 1);
    @(posedge clk); #1;
    finish = 1'b0;
    check("fin_again_done", done, 1);
    check("fin_again_idle", busy, 0);

    // reset during WRITE
    do_start();
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, ok);
    check("rw_we_before", imem_we, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rw_we", imem_we, 0);
    check("rw_count", count, 0);
    check("rw_addr", imem_addr, 0);
    check("rw_wdata", imem_wdata, 0);
    check("rw_busy", busy, 0);
    check("rw_ready", in_ready, 0);
    rst = 1'b0;
    do_start();
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5, ok);
    check("rw_restart_addr", imem_addr, 0);
    check("rw_restart_we", imem_we, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
